// File: rtl/eq_spi_pkg.sv
// eq_spi_pkg: shared state encoding and default sizing for the eq_spi master
package eq_spi_pkg;
  typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, TRAIL} state_t;
  localparam int EQ_SPI_WIDTH = 32;
  localparam int EQ_SPI_CLK_DIV = 4;
endpackage

// File: rtl/spi_sck_gen.sv
// spi_sck_gen: half-period divider; ports clk, reset, en in, half_tick out (one-cycle strobe every CLK_DIV enabled cycles)
module spi_sck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic half_tick
);
  localparam int CW = $clog2(CLK_DIV) + 1;
  logic [CW-1:0] cnt;
  assign half_tick = en && (cnt == CW'(CLK_DIV - 1));
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= (!en || half_tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/eq_spi_master.sv
// eq_spi_master: mode-0 SPI initiator; start/tx_data in, rx_data/busy/done out, sck/ce/sdo/sdi serial link
module eq_spi_master import eq_spi_pkg::*; #(
  parameter int WIDTH = EQ_SPI_WIDTH,
  parameter int CLK_DIV = EQ_SPI_CLK_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] tx_data,
  output logic [WIDTH-1:0] rx_data,
  output logic             busy,
  output logic             done,
  output logic             sck,
  output logic             ce,
  output logic             sdo,
  input  logic             sdi
);
  localparam int BW = $clog2(WIDTH) + 1;
  generate
    if (CLK_DIV < 1) begin : g_bad_div
      $error("CLK_DIV must be >= 1");
    end
  endgenerate
  state_t state;
  logic [WIDTH-2:0] tx_sr;
  logic [WIDTH-1:0] rx_sr;
  logic [BW-1:0] bit_cnt;
  logic half_tick;
  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk(clk),
    .reset(reset),
    .en(state != IDLE),
    .half_tick(half_tick)
  );
  // tx_sr holds only the bits not yet on sdo; the MSB goes straight to sdo on accept
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      tx_sr <= '0;
      rx_sr <= '0;
      rx_data <= '0;
      bit_cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      sck <= 1'b0;
      ce <= 1'b0;
      sdo <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          tx_sr <= tx_data[WIDTH-2:0];
          sdo <= tx_data[WIDTH-1];
          ce <= 1'b1;
          busy <= 1'b1;
          state <= LEAD;
        end
        LEAD, LOW: if (half_tick) begin
          sck <= 1'b1;
          rx_sr <= {rx_sr[WIDTH-2:0], sdi};
          state <= HIGH;
        end
        HIGH: if (half_tick) begin
          sck <= 1'b0;
          if (bit_cnt == BW'(WIDTH - 1)) begin
            bit_cnt <= '0;
            state <= TRAIL;
          end else begin
            sdo <= tx_sr[WIDTH-2];
            tx_sr <= {tx_sr[WIDTH-3:0], 1'b0};
            bit_cnt <= bit_cnt + 1'b1;
            state <= LOW;
          end
        end
        TRAIL: if (half_tick) begin
          ce <= 1'b0;
          sdo <= 1'b0;
          busy <= 1'b0;
          done <= 1'b1;
          rx_data <= rx_sr;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_eq_spi_master.sv
// tb_eq_spi_master: scoreboard bench for eq_spi_master (default divider and CLK_DIV=1 instances)
module tb_eq_spi_master;
  logic clk = 0, reset = 1, start0 = 0, start1 = 0, sdi_mode = 0;
  logic [31:0] tx0 = 0, tx1 = 0, rx0, rx1, rcv = 0, exp, rx_at;
  logic busy0, busy1, done0, done1, sck0, sck1, ce0, ce1, sdo0, sdo1, sdi0, sdi1;
  logic prev_sdo = 0;
  int stab_err = 0, checks = 0, failures = 0;
  int done_at, ndone, rises, ce_err, sdo_ones;
  logic [31:0] q[$];
  assign sdi0 = sdi_mode ? 1'b1 : sdo0;
  assign sdi1 = sdo1;
  always #5 clk = ~clk;

  eq_spi_master dut0 (.clk(clk), .reset(reset), .start(start0), .tx_data(tx0), .rx_data(rx0),
    .busy(busy0), .done(done0), .sck(sck0), .ce(ce0), .sdo(sdo0), .sdi(sdi0));
  eq_spi_master #(.WIDTH(32), .CLK_DIV(1)) dut1 (.clk(clk), .reset(reset), .start(start1), .tx_data(tx1),
    .rx_data(rx1), .busy(busy1), .done(done1), .sck(sck1), .ce(ce1), .sdo(sdo1), .sdi(sdi1));

  // receiving peripheral: samples sdo on rising sck while ce is high
  always @(posedge sck0) if (ce0) rcv <= {rcv[30:0], sdo0};
  // sdo must not move in any cycle where sck is high (including the rising cycle)
  always @(negedge clk) begin
    if (sck0 && sdo0 !== prev_sdo) stab_err++;
    prev_sdo = sdo0;
  end

  task automatic kick0(input logic [31:0] tx, input logic [31:0] want);
    @(negedge clk);
    tx0 = tx;
    start0 = 1;
    q.push_back(want);
  endtask

  // observe dut0 for limit cycles after the accept edge; cycle k is seen after k negedges
  task automatic run0(input int limit, input bit act, input int pulse_at);
    logic prev = 0;
    done_at = -1; ndone = 0; rises = 0; ce_err = 0; sdo_ones = 0; rx_at = 'x;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (k == 1 || k == pulse_at + 1) start0 = 0;
      if (k == pulse_at) begin start0 = 1; tx0 = 0; end
      if (sck0 && !prev) rises++;
      prev = sck0;
      if (ce0 !== (act && k <= 260)) ce_err++;
      if (sdo0 === 1'b1) sdo_ones++;
      if (done0) begin
        ndone++;
        if (done_at < 0) begin done_at = k; rx_at = rx0; end
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if ({busy0, done0, sck0, ce0, sdo0} !== 5'b0) begin failures++; $display("FAIL reset_ctl0 got=%b want=00000", {busy0, done0, sck0, ce0, sdo0}); end
    checks++; if (rx0 !== 32'h0) begin failures++; $display("FAIL reset_rx0 got=%h want=0", rx0); end
    checks++; if ({busy1, done1, sck1, ce1, sdo1, rx1} !== 37'b0) begin failures++; $display("FAIL reset_dut1 got=%h want=0", {busy1, done1, sck1, ce1, sdo1, rx1}); end
    reset = 0;
  endtask

  task automatic test_loopback;
    kick0(32'hA5C3_0F81, 32'hA5C3_0F81);
    run0(300, 1, 0);
    checks++; if (done_at != 261) begin failures++; $display("FAIL loop_done_cycle got=%0d want=261", done_at); end
    exp = q.size() ? q.pop_front() : 'x;
    checks++; if (rx_at !== exp) begin failures++; $display("FAIL loop_rx got=%h want=%h", rx_at, exp); end
    checks++; if (rises != 32) begin failures++; $display("FAIL loop_sck_rises got=%0d want=32", rises); end
    checks++; if (ce_err != 0) begin failures++; $display("FAIL loop_ce_window bad_cycles=%0d want=0", ce_err); end
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL loop_busy_after got=%b want=0", busy0); end
  endtask

  task automatic test_receiver;
    stab_err = 0;
    rcv = 0;
    kick0(32'h1234_5678, 32'h1234_5678);
    run0(300, 1, 0);
    checks++; if (rcv !== 32'h1234_5678) begin failures++; $display("FAIL rcv_word got=%h want=12345678", rcv); end
    checks++; if (stab_err != 0) begin failures++; $display("FAIL sdo_stability violations=%0d want=0", stab_err); end
    exp = q.size() ? q.pop_front() : 'x;
    checks++; if (rx_at !== exp) begin failures++; $display("FAIL rcv_rx got=%h want=%h", rx_at, exp); end
  endtask

  task automatic test_ignore_start;
    kick0(32'h5A5A_F00F, 32'h5A5A_F00F);
    run0(400, 1, 50);
    checks++; if (ndone != 1) begin failures++; $display("FAIL ign_done_count got=%0d want=1", ndone); end
    checks++; if (done_at != 261) begin failures++; $display("FAIL ign_done_cycle got=%0d want=261", done_at); end
    exp = q.size() ? q.pop_front() : 'x;
    checks++; if (rx_at !== exp) begin failures++; $display("FAIL ign_rx got=%h want=%h", rx_at, exp); end
    checks++; if (ce_err != 0) begin failures++; $display("FAIL ign_ce_window bad_cycles=%0d want=0", ce_err); end
  endtask

  task automatic test_reset_mid;
    kick0(32'h8001_7FFE, 32'h8001_7FFE);
    run0(99, 1, 0);
    @(negedge clk);
    #1 reset = 1;
    #1;
    checks++; if ({sck0, ce0, busy0, sdo0} !== 4'b0) begin failures++; $display("FAIL midrst_ctl got=%b want=0000", {sck0, ce0, busy0, sdo0}); end
    checks++; if (rx0 !== 32'h0) begin failures++; $display("FAIL midrst_rx got=%h want=0", rx0); end
    exp = q.pop_back();
    @(negedge clk);
    reset = 0;
    run0(300, 0, 0);
    checks++; if (ndone != 0) begin failures++; $display("FAIL midrst_no_done got=%0d want=0", ndone); end
    checks++; if (ce_err != 0) begin failures++; $display("FAIL midrst_ce_idle bad_cycles=%0d want=0", ce_err); end
    kick0(32'h0F0F_3C3C, 32'h0F0F_3C3C);
    run0(300, 1, 0);
    checks++; if (done_at != 261) begin failures++; $display("FAIL midrst_next_done got=%0d want=261", done_at); end
    exp = q.size() ? q.pop_front() : 'x;
    checks++; if (rx_at !== exp) begin failures++; $display("FAIL midrst_next_rx got=%h want=%h", rx_at, exp); end
  endtask

  task automatic test_back_to_back;
    int d1 = -1, d2 = -1, ce_low = 0;
    logic [31:0] r1 = 'x, r2 = 'x;
    @(negedge clk);
    tx1 = 32'hFFFF_FFFF;
    start1 = 1;
    q.push_back(32'hFFFF_FFFF);
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (done1) begin
        if (d1 < 0) begin d1 = k; r1 = rx1; tx1 = 32'h0000_0001; q.push_back(32'h0000_0001); end
        else if (d2 < 0) begin d2 = k; r2 = rx1; start1 = 0; end
      end
      if (!ce1 && d2 < 0) ce_low++;
    end
    start1 = 0;
    checks++; if (d1 != 66) begin failures++; $display("FAIL b2b_done1 got=%0d want=66", d1); end
    checks++; if (d2 != 132) begin failures++; $display("FAIL b2b_done2 got=%0d want=132", d2); end
    exp = q.size() ? q.pop_front() : 'x;
    checks++; if (r1 !== exp) begin failures++; $display("FAIL b2b_rx1 got=%h want=%h", r1, exp); end
    exp = q.size() ? q.pop_front() : 'x;
    checks++; if (r2 !== exp) begin failures++; $display("FAIL b2b_rx2 got=%h want=%h", r2, exp); end
    checks++; if (ce_low != 1) begin failures++; $display("FAIL b2b_ce_gap got=%0d want=1", ce_low); end
  endtask

  task automatic test_sdi_ones;
    sdi_mode = 1;
    kick0(32'h0, 32'hFFFF_FFFF);
    run0(300, 1, 0);
    sdi_mode = 0;
    exp = q.size() ? q.pop_front() : 'x;
    checks++; if (rx_at !== exp) begin failures++; $display("FAIL ones_rx got=%h want=%h", rx_at, exp); end
    checks++; if (sdo_ones != 0) begin failures++; $display("FAIL ones_sdo_high cycles=%0d want=0", sdo_ones); end
    checks++; if (done_at != 261) begin failures++; $display("FAIL ones_done got=%0d want=261", done_at); end
  endtask

  initial begin
    test_reset;
    test_loopback;
    test_receiver;
    test_ignore_start;
    test_reset_mid;
    test_back_to_back;
    test_sdi_ones;
    checks++; if (q.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d want=0", q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
